sa_cache_ctrl: RTL

- Parametrised N-way set-associative, write-back, write-allocate cache controller.
- Successor to the fixed 2-way/8-bit cache: width, depth and associativity are generalised, and replacement is true LRU.
- Sits between the processor port (pr_*) and the line-wide memory bus (bus_*) that drives the Memory model.
- Optional hit/miss/writeback counters.

---
 rtl/sa_cache_pkg.sv | 28 ++
 rtl/sa_cache_lru.sv | 48 ++++
 rtl/sa_cache_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sa_cache_pkg.sv
// Shared types and derived-width helpers for the set-associative cache controller.
package sa_cache_pkg;

  typedef enum logic [2:0] {
    StMonitor = 3'b001,
    StWb      = 3'b010,
    StFetch   = 3'b100
  } state_e;

  function automatic int unsigned off_w(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned words,
                                        input int unsigned sets);
    return addr_w - off_w(words) - idx_w(sets);
  endfunction

  // A direct-mapped build still needs a 1-bit way select.
  function automatic int unsigned way_w(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/sa_cache_lru.sv
// Per-set true-LRU age array: age 0 is MRU, age WAYS-1 is the replacement candidate.
module sa_cache_lru
  import sa_cache_pkg::*;
#(
  parameter int unsigned SETS = 4,
  parameter int unsigned WAYS = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [idx_w(SETS)-1:0]   set_i,
  input  logic                     touch_i,
  input  logic [way_w(WAYS)-1:0]   way_i,
  output logic [way_w(WAYS)-1:0]   lru_way_o
);

  localparam int unsigned WAY_W = way_w(WAYS);

  logic [WAY_W-1:0] age_q [SETS][WAYS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else if (touch_i) begin
      // Only ways younger than the touched one shift, so ages stay a permutation.
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == way_i) begin
          age_q[set_i][w] <= '0;
        end else if (age_q[set_i][w] < age_q[set_i][way_i]) begin
          age_q[set_i][w] <= age_q[set_i][w] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    lru_way_o = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (age_q[set_i][w] == WAY_W'(WAYS - 1)) begin
        lru_way_o = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/sa_cache_ctrl.sv
// N-way set-associative write-back/write-allocate cache controller with true-LRU replacement.
// Define CACHE_PERF_CNT_EN to add saturating hit/miss/writeback counters.
module sa_cache_ctrl
  import sa_cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WORDS  = 2,
  parameter int unsigned SETS   = 4,
  parameter int unsigned WAYS   = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ADDR_W-1:0]                pr_addr,
  input  logic [DATA_W-1:0]                pr_din,
  input  logic                             pr_rd,
  input  logic                             pr_wr,
  output logic [DATA_W-1:0]                pr_dout,
  output logic                             pr_done,
  output logic [ADDR_W-off_w(WORDS)-1:0]   bus_addr,
  output logic [WORDS*DATA_W-1:0]          bus_dout,
  input  logic [WORDS*DATA_W-1:0]          bus_din,
  output logic                             bus_rd,
  output logic                             bus_wr,
`ifdef CACHE_PERF_CNT_EN
  output logic [15:0]                      hit_cnt,
  output logic [15:0]                      miss_cnt,
  output logic [15:0]                      wb_cnt,
`endif
  input  logic                             bus_done
);

  localparam int unsigned OFF_W  = off_w(WORDS);
  localparam int unsigned IDX_W  = idx_w(SETS);
  localparam int unsigned TAG_W  = tag_w(ADDR_W, WORDS, SETS);
  localparam int unsigned WAY_W  = way_w(WAYS);
  localparam int unsigned LINE_W = WORDS * DATA_W;
  localparam int unsigned LA_W   = ADDR_W - OFF_W;

  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS][WORDS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];

  state_e            state_q;
  logic [WAY_W-1:0]  victim_q;
  logic              replay_q;
  logic              pr_done_q;
  logic [DATA_W-1:0] pr_dout_q;
  logic              bus_rd_q, bus_wr_q;
  logic [LA_W-1:0]   bus_addr_q;
  logic [LINE_W-1:0] bus_dout_q;

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              req;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  lru_way;
  logic [WAY_W-1:0]  victim_way;
  logic              inv_found;
  logic [LINE_W-1:0] victim_line;
  logic              lookup;
  logic              hit_evt;
  logic              fill_evt;

  assign req_off = pr_addr[OFF_W-1:0];
  assign req_idx = pr_addr[OFF_W +: IDX_W];
  assign req_tag = pr_addr[ADDR_W-1 -: TAG_W];
  assign req     = pr_rd | pr_wr;

  // The cycle after pr_done is never a lookup, so a held request is seen once.
  assign lookup   = (state_q == StMonitor) && req && !pr_done_q;
  assign hit_evt  = lookup && hit;
  assign fill_evt = (state_q == StFetch) && bus_done;

  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    inv_found   = 1'b0;
    victim_way  = lru_way;
    victim_line = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!inv_found && !valid_q[req_idx][w]) begin
        inv_found  = 1'b1;
        victim_way = WAY_W'(w);
      end
    end
    for (int unsigned k = 0; k < WORDS; k++) begin
      victim_line[k*DATA_W +: DATA_W] = data_q[req_idx][victim_way][k];
    end
  end

  sa_cache_lru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clk_i     (clk),
    .rst_ni    (reset),
    .set_i     (req_idx),
    .touch_i   (hit_evt),
    .way_i     (hit_way),
    .lru_way_o (lru_way)
  );

`ifdef CACHE_PERF_CNT_EN
  logic [15:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StMonitor;
      victim_q   <= '0;
      replay_q   <= 1'b0;
      pr_done_q  <= 1'b0;
      pr_dout_q  <= '0;
      bus_rd_q   <= 1'b0;
      bus_wr_q   <= 1'b0;
      bus_addr_q <= '0;
      bus_dout_q <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
`ifdef CACHE_PERF_CNT_EN
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
`endif
    end else begin
      pr_done_q <= 1'b0;
      unique case (state_q)
        StMonitor: begin
          if (hit_evt) begin
            pr_done_q <= 1'b1;
            replay_q  <= 1'b0;
            if (pr_wr) begin
              dirty_q[req_idx][hit_way] <= 1'b1;
            end else begin
              pr_dout_q <= data_q[req_idx][hit_way][req_off];
            end
`ifdef CACHE_PERF_CNT_EN
            if (!replay_q && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
`endif
          end else if (lookup) begin
            victim_q <= victim_way;
`ifdef CACHE_PERF_CNT_EN
            if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
`endif
            if (valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way]) begin
              state_q    <= StWb;
              bus_wr_q   <= 1'b1;
              bus_addr_q <= {tag_q[req_idx][victim_way], req_idx};
              bus_dout_q <= victim_line;
            end else begin
              state_q    <= StFetch;
              bus_rd_q   <= 1'b1;
              bus_addr_q <= {req_tag, req_idx};
            end
          end
        end
        StWb: begin
          if (bus_done) begin
            state_q    <= StFetch;
            bus_wr_q   <= 1'b0;
            bus_rd_q   <= 1'b1;
            bus_addr_q <= {req_tag, req_idx};
`ifdef CACHE_PERF_CNT_EN
            if (wb_cnt_q != 16'hFFFF) wb_cnt_q <= wb_cnt_q + 16'd1;
`endif
          end
        end
        StFetch: begin
          if (bus_done) begin
            state_q                    <= StMonitor;
            bus_rd_q                   <= 1'b0;
            valid_q[req_idx][victim_q] <= 1'b1;
            dirty_q[req_idx][victim_q] <= 1'b0;
            replay_q                   <= 1'b1;
          end
        end
        default: state_q <= StMonitor;
      endcase
    end
  end

  // Tag and data storage are deliberately not reset.
  always_ff @(posedge clk) begin
    if (hit_evt && pr_wr) begin
      data_q[req_idx][hit_way][req_off] <= pr_din;
    end
    if (fill_evt) begin
      tag_q[req_idx][victim_q] <= req_tag;
      for (int unsigned k = 0; k < WORDS; k++) begin
        data_q[req_idx][victim_q][k] <= bus_din[k*DATA_W +: DATA_W];
      end
    end
  end

  assign pr_done  = pr_done_q;
  assign pr_dout  = pr_dout_q;
  assign bus_rd   = bus_rd_q;
  assign bus_wr   = bus_wr_q;
  assign bus_addr = bus_addr_q;
  assign bus_dout = bus_dout_q;

endmodule
